// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty sequencer: FSM encodings and default widths.
package pwm_ctrl_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_STEP_W = 4;
  localparam int PWM_HOLD_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational saturating step: moves duty toward target by at most step
// (step 0 = jump straight there) without overshoot or wrap.
module pwm_ramp_step
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int STEP_W = PWM_STEP_W
) (
  input  logic [WIDTH-1:0]  duty,
  input  logic [WIDTH-1:0]  target,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  next_duty,
  output logic              at_target
);

  logic [WIDTH:0] duty_x_s;
  logic [WIDTH:0] target_x_s;
  logic [WIDTH:0] step_x_s;
  logic [WIDTH:0] diff_s;
  logic [WIDTH:0] move_s;
  logic [WIDTH:0] next_x_s;
  logic           up_s;

  // Distance to target, clamped step, and the resulting duty in WIDTH+1 bits
  always_comb begin
    duty_x_s   = {1'b0, duty};
    target_x_s = {1'b0, target};
    step_x_s   = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    up_s       = (target_x_s > duty_x_s);
    if (up_s) begin
      diff_s = target_x_s - duty_x_s;
    end else begin
      diff_s = duty_x_s - target_x_s;
    end
    if ((step == {STEP_W{1'b0}}) || (step_x_s > diff_s)) begin
      move_s = diff_s;
    end else begin
      move_s = step_x_s;
    end
    if (up_s) begin
      next_x_s = duty_x_s + move_s;
    end else begin
      next_x_s = duty_x_s - move_s;
    end
    next_duty = next_x_s[WIDTH-1:0];
    at_target = (next_x_s == target_x_s);
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty sequencer: accepts ramp commands and walks duty_o toward the target,
// updating only at PWM period boundaries.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int STEP_W = PWM_STEP_W,
  parameter int HOLD_W = PWM_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              period_end_i,
  input  logic              abort_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [WIDTH-1:0]  cmd_target_i,
  input  logic [STEP_W-1:0] cmd_step_i,
  input  logic [HOLD_W-1:0] cmd_hold_i,
  output logic [WIDTH-1:0]  duty_o,
  output logic              busy_o,
  output logic              done_o
);

  ramp_state_e       state_r, state_s;
  logic [WIDTH-1:0]  duty_r, duty_s;
  logic [WIDTH-1:0]  target_r, target_s;
  logic [STEP_W-1:0] step_r, step_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic              done_r, done_s;
  logic [WIDTH-1:0]  next_duty_s;
  logic              at_target_s;

  pwm_ramp_step #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .duty      (duty_r),
    .target    (target_r),
    .step      (step_r),
    .next_duty (next_duty_s),
    .at_target (at_target_s)
  );

  assign cmd_ready_o = (state_r == ST_IDLE) && !abort_i;
  assign duty_o      = duty_r;
  assign busy_o      = (state_r == ST_RAMP);
  assign done_o      = done_r;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      duty_r     <= {WIDTH{1'b0}};
      target_r   <= {WIDTH{1'b0}};
      step_r     <= {STEP_W{1'b0}};
      hold_r     <= {HOLD_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      duty_r     <= duty_s;
      target_r   <= target_s;
      step_r     <= step_s;
      hold_r     <= hold_s;
      hold_cnt_r <= hold_cnt_s;
      done_r     <= done_s;
    end
  end

  // Next-state logic; abort overrides everything, period_end_i in IDLE is ignored
  always_comb begin
    state_s    = state_r;
    duty_s     = duty_r;
    target_s   = target_r;
    step_s     = step_r;
    hold_s     = hold_r;
    hold_cnt_s = hold_cnt_r;
    done_s     = 1'b0;
    if (abort_i) begin
      state_s = ST_IDLE;
      duty_s  = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            target_s   = cmd_target_i;
            step_s     = cmd_step_i;
            hold_s     = cmd_hold_i;
            hold_cnt_s = cmd_hold_i;
            state_s    = ST_RAMP;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RAMP: begin
          if (!period_end_i) begin
            state_s = ST_RAMP;
          end else if (hold_cnt_r != {HOLD_W{1'b0}}) begin
            hold_cnt_s = hold_cnt_r - {{(HOLD_W - 1){1'b0}}, 1'b1};
          end else begin
            duty_s     = next_duty_s;
            hold_cnt_s = hold_r;
            if (at_target_s) begin
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RAMP;
            end
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with hand-computed expected duty/handshake values.
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       rst_i;
  logic       period_end_i;
  logic       abort_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] cmd_target_i;
  logic [3:0] cmd_step_i;
  logic [7:0] cmd_hold_i;
  logic [7:0] duty_o;
  logic       busy_o;
  logic       done_o;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_ramp_ctrl dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .period_end_i (period_end_i),
    .abort_i      (abort_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_target_i (cmd_target_i),
    .cmd_step_i   (cmd_step_i),
    .cmd_hold_i   (cmd_hold_i),
    .duty_o       (duty_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pe();
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] tgt, input logic [3:0] stp, input logic [7:0] hld);
    cmd_target_i = tgt;
    cmd_step_i   = stp;
    cmd_hold_i   = hld;
    cmd_valid_i  = 1'b1;
    tick();
    cmd_valid_i  = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; period_end_i = 1'b0; abort_i = 1'b0; cmd_valid_i = 1'b0;
    cmd_target_i = 8'd0; cmd_step_i = 4'd0; cmd_hold_i = 8'd0;
    tick(); tick();
    rst_i = 1'b0;
    check_val("rst_duty", duty_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_ready", cmd_ready_o, 1);

    // Hold: target 6, step 3, hold 2 from 0
    send(8'd6, 4'd3, 8'd2);
    check_val("hold_busy", busy_o, 1);
    check_val("hold_ready", cmd_ready_o, 0);
    pulse_pe(); pulse_pe();
    check_val("hold_pe2", duty_o, 0);
    pulse_pe();
    check_val("hold_pe3", duty_o, 3);
    check_val("hold_pe3_done", done_o, 0);
    pulse_pe(); pulse_pe();
    check_val("hold_pe5", duty_o, 3);
    pulse_pe();
    check_val("hold_pe6", duty_o, 6);
    check_val("hold_done", done_o, 1);
    tick();
    check_val("hold_done_clr", done_o, 0);

    // Reset mid-ramp at duty 40
    send(8'd40, 4'd0, 8'd0);
    pulse_pe();
    check_val("jump40", duty_o, 40);
    send(8'd100, 4'd10, 8'd0);
    check_val("mid_busy", busy_o, 1);
    check_val("mid_duty", duty_o, 40);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_val("mrst_duty", duty_o, 0);
    check_val("mrst_busy", busy_o, 0);
    check_val("mrst_ready", cmd_ready_o, 1);

    // Ramp up 0 -> 10 step 4
    send(8'd10, 4'd4, 8'd0);
    check_val("up_accept_duty", duty_o, 0);
    pulse_pe();
    check_val("up_1", duty_o, 4);
    check_val("up_1_done", done_o, 0);
    pulse_pe();
    check_val("up_2", duty_o, 8);
    check_val("up_2_done", done_o, 0);
    pulse_pe();
    check_val("up_3", duty_o, 10);
    check_val("up_3_done", done_o, 1);
    check_val("up_3_busy", busy_o, 0);
    tick();
    check_val("up_done_once", done_o, 0);

    // Ramp down without undershoot, then jump to top
    send(8'd200, 4'd0, 8'd0);
    pulse_pe();
    check_val("to200", duty_o, 200);
    send(8'd197, 4'd5, 8'd0);
    pulse_pe();
    check_val("down197", duty_o, 197);
    check_val("down197_done", done_o, 1);
    send(8'd255, 4'd0, 8'd0);
    pulse_pe();
    check_val("jump255", duty_o, 255);
    check_val("jump255_done", done_o, 1);

    // period_end_i in IDLE ignored
    tick();
    pulse_pe();
    check_val("idle_pe_duty", duty_o, 255);
    check_val("idle_pe_done", done_o, 0);

    // Accept coinciding with period_end_i: that edge does not count
    period_end_i = 1'b1;
    send(8'd245, 4'd10, 8'd0);
    period_end_i = 1'b0;
    check_val("acc_pe_duty", duty_o, 255);
    check_val("acc_pe_busy", busy_o, 1);
    pulse_pe();
    check_val("acc_pe_245", duty_o, 245);
    check_val("acc_pe_done", done_o, 1);

    // Abort during ramp with cmd_valid_i high
    send(8'd100, 4'd1, 8'd0);
    pulse_pe();
    check_val("abrt_pre", duty_o, 244);
    abort_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_target_i = 8'd50; cmd_step_i = 4'd2; cmd_hold_i = 8'd0;
    #1;
    check_val("abrt_ready0", cmd_ready_o, 0);
    tick();
    check_val("abrt_duty", duty_o, 0);
    check_val("abrt_busy", busy_o, 0);
    check_val("abrt_done", done_o, 0);
    check_val("abrt_ready_idle", cmd_ready_o, 0);
    tick();
    check_val("abrt_no_accept", busy_o, 0);
    abort_i = 1'b0;
    cmd_valid_i = 1'b0;
    tick();

    // target equal to duty: completes on first eligible period_end_i
    send(8'd0, 4'd5, 8'd0);
    check_val("eq_busy", busy_o, 1);
    pulse_pe();
    check_val("eq_duty", duty_o, 0);
    check_val("eq_done", done_o, 1);

    // Back-pressure: second command held valid through the ramp
    send(8'd8, 4'd4, 8'd1);
    cmd_valid_i = 1'b1; cmd_target_i = 8'd30; cmd_step_i = 4'd0; cmd_hold_i = 8'd0;
    pulse_pe();
    check_val("bp_hold", duty_o, 0);
    pulse_pe();
    check_val("bp_4", duty_o, 4);
    check_val("bp_busy", busy_o, 1);
    pulse_pe();
    check_val("bp_still4", duty_o, 4);
    pulse_pe();
    check_val("bp_8", duty_o, 8);
    check_val("bp_done", done_o, 1);
    check_val("bp_ready", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    check_val("bp_accepted", busy_o, 1);
    check_val("bp_acc_duty", duty_o, 8);
    pulse_pe();
    check_val("bp_30", duty_o, 30);
    check_val("bp_30_done", done_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
